// File: rtl/la_counter_bank.sv
`default_nettype none
// ============================================================================
// Module   : la_counter_bank
// Purpose  : Bank of prescaled up/down counters with wrap/saturate, sticky
//            compare match and a shared interrupt, driven from LA probes.
// Revision : 1.0
// ============================================================================
module la_counter_bank #(
  parameter int CHANNELS   = 4,
  parameter int WIDTH      = 16,
  parameter int PRESCALE_W = 8
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic [CHANNELS-1:0]       en_i,
  input  logic [CHANNELS-1:0]       dir_i,
  input  logic [CHANNELS-1:0]       sat_i,
  input  logic [CHANNELS-1:0]       load_i,
  input  logic [CHANNELS*WIDTH-1:0] load_val_i,
  input  logic [CHANNELS*WIDTH-1:0] cmp_val_i,
  input  logic [CHANNELS-1:0]       match_clr_i,
  input  logic [CHANNELS-1:0]       irq_en_i,
  input  logic [PRESCALE_W-1:0]     prescale_i,
  output logic [CHANNELS*WIDTH-1:0] count_o,
  output logic [CHANNELS-1:0]       match_o,
  output logic [CHANNELS-1:0]       event_o,
  output logic                      tick_o,
  output logic                      irq_o
);

  localparam logic [WIDTH-1:0] c_ONES = '1;

  logic [PRESCALE_W-1:0] r_psc;
  logic                  r_tick;
  logic                  r_irq;

  // >= so that lowering prescale_i mid-count ticks at once instead of rolling over
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_psc  <= '0;
      r_tick <= 1'b0;
    end else if (r_psc >= prescale_i) begin
      r_psc  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_psc  <= r_psc + 1'b1;
      r_tick <= 1'b0;
    end
  end

  assign tick_o = r_tick;

  for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic             w_evt_nxt;
    logic             w_hit;
    logic             r_event;
    logic             r_match;

    always_comb begin
      w_cnt_nxt = r_count;
      w_evt_nxt = 1'b0;
      if (load_i[n]) begin
        w_cnt_nxt = load_val_i[n*WIDTH +: WIDTH];
      end else if (r_tick && en_i[n]) begin
        if (dir_i[n]) begin
          if (r_count == c_ONES) begin
            if (!sat_i[n]) begin
              w_cnt_nxt = '0;
              w_evt_nxt = 1'b1;
            end
          end else begin
            w_cnt_nxt = r_count + 1'b1;
            w_evt_nxt = sat_i[n] && (w_cnt_nxt == c_ONES);
          end
        end else begin
          if (r_count == '0) begin
            if (!sat_i[n]) begin
              w_cnt_nxt = c_ONES;
              w_evt_nxt = 1'b1;
            end
          end else begin
            w_cnt_nxt = r_count - 1'b1;
            w_evt_nxt = sat_i[n] && (w_cnt_nxt == '0);
          end
        end
      end
    end

    assign w_hit = (r_count == cmp_val_i[n*WIDTH +: WIDTH]);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
        r_count <= '0;
        r_event <= 1'b0;
        r_match <= 1'b0;
      end else begin
        r_count <= w_cnt_nxt;
        r_event <= w_evt_nxt;
        // a live compare hit overrides a clear request in the same cycle
        r_match <= w_hit | (r_match & ~match_clr_i[n]);
      end
    end

    assign count_o[n*WIDTH +: WIDTH] = r_count;
    assign event_o[n]                = r_event;
    assign match_o[n]                = r_match;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= |(match_o & irq_en_i);
    end
  end

  assign irq_o = r_irq;

endmodule
`default_nettype wire

// File: doc/la_counter_bank.md
# la_counter_bank

Parametrised multi-channel counter bank for the user project area, controlled and observed through the logic-analyzer (LA) probes. It generalises the single LA-driven test counter to CHANNELS independent counters of WIDTH bits. Each channel has load, direction, wrap/saturate mode, compare-match and event outputs. A shared prescaler paces all channels. Outputs route to la_data_out for firmware readback and to mprj_io for external benches.

## Interface
Parameters:
- CHANNELS, 4, number of independent counter channels (1..8)
- WIDTH, 16, counter width in bits (2..32)
- PRESCALE_W, 8, width of the shared prescaler

Ports:
- wb_clk_i  in  1  single clock for all logic
- wb_rst_i  in  1  asynchronous, active-high reset
- en_i  in  CHANNELS  per-channel count enable
- dir_i  in  CHANNELS  per-channel direction: 1 = up, 0 = down
- sat_i  in  CHANNELS  per-channel mode: 1 = saturate at bound, 0 = wrap
- load_i  in  CHANNELS  per-channel synchronous load strobe
- load_val_i  in  CHANNELS*WIDTH  load values; channel n uses bits [n*WIDTH +: WIDTH]
- cmp_val_i  in  CHANNELS*WIDTH  compare values, same packing
- match_clr_i  in  CHANNELS  per-channel clear of the sticky match flag
- irq_en_i  in  CHANNELS  per-channel interrupt enable
- prescale_i  in  PRESCALE_W  tick period minus one (0 = step every cycle)
- count_o  out  CHANNELS*WIDTH  registered counter values
- match_o  out  CHANNELS  sticky compare-match flags
- event_o  out  CHANNELS  one-cycle pulse on wrap or on reaching a saturation bound
- tick_o  out  1  one-cycle prescaler tick, exported for observation
- irq_o  out  1  registered OR over channels of (match_o & irq_en_i)

## Operation
Prescaler:
- Counter psc, PRESCALE_W bits.
- When psc >= prescale_i: psc <= 0 and tick <= 1.
- Otherwise psc increments and tick <= 0.
- Using >= means lowering prescale_i mid-count yields a tick on the next cycle, never a long rollover.

Per channel n, in priority order each cycle:
1. load_i[n]: count <= load_val. This happens regardless of en_i and tick. No event is generated.
2. tick & en_i[n] & dir_i[n] (up):
   - count == all-ones and sat: count holds; event pulses only on the step that reached all-ones.
   - count == all-ones and wrap: count <= 0, event <= 1.
   - Otherwise count + 1.
3. tick & en_i[n] & ~dir_i[n] (down): mirror of the up case, with bound 0 and wrap target all-ones.
4. Otherwise: hold.

Saturation event:
- Fires on the step whose result equals the bound.
- Does not repeat while the counter is held at the bound.
- If a load places the counter at the bound, no event fires.

Match:
- Compare uses the registered count: match set condition = (count == cmp_val).
- Set and clear in the same cycle: set wins.
- Once set, match_o stays set until match_clr_i is asserted with the condition false.

irq_o is registered and follows match_o by one cycle.

Changing sat_i or dir_i takes effect on the next tick. There is no pipeline to flush.

## Timing
- Reset (async, all outputs): count_o = 0, match_o = 0, event_o = 0, tick_o = 0, irq_o = 0, psc = 0.
- Reset mid-operation clears state immediately. Counting resumes on the first tick after deassertion; with prescale_i = P, that is P+1 cycles after deassertion.
- Load latency: count_o shows load_val one cycle after the load_i edge.
- Step latency: count_o updates on the cycle after tick_o is high (tick and count update registered in the same stage as the count).
- event_o: high in the same cycle count_o shows the wrapped or bound value.
- match_o: high one cycle after count_o equals cmp_val.
- irq_o: high one cycle after match_o.

## Test plan
- Reset + free run: prescale_i=0, ch0 up/wrap, WIDTH=16 → count_o[0] = 0,1,2,… each cycle. After 65536 steps it returns to 0 with event_o[0] high for exactly that one cycle.
- Prescaler: prescale_i=3 → tick_o high every 4th cycle. Then drop prescale_i to 1 while psc=3 → tick on the next cycle, then every 2 cycles.
- Saturate down: load ch1 = 2, dir=0, sat=1 → 1, 0 with event_o[1] on 0 only. The count stays 0 for 10 further ticks with no further events.
- Load priority: load_i[2]=1 with tick & en high, load_val=0x1234 → count_o[2]=0x1234 next cycle, not 0x1235.
- Match/irq: cmp_val ch3 = 5, irq_en_i[3]=1, count up from 0.
  - Count reaches 5 → match_o[3] high one cycle later, irq_o high one cycle after that.
  - Assert match_clr_i while count==5 → match stays set.
  - Assert match_clr_i at count 6 → match and irq clear.
- Async reset mid-count: assert wb_rst_i between clock edges with counts nonzero → all outputs 0 immediately without a clock edge. After release with prescale_i=2 → first increment is visible 4 cycles later.
